// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
//   Shares the single-port data memory between port A (CPU MEM stage) and
//   port B (debug/test loader). A request is granted in IDLE, issued to the
//   DM for exactly one ACCESS cycle, and acknowledged in DONE, so one access
//   completes every three cycles at best. Under contention the port that
//   did not win last time is granted.
//
//   State table:
//     IDLE   | sample requests, pick winner, latch its request
//     ACCESS | drive DM from latched request, capture rdata/err
//     DONE   | one-cycle ack to the winner
//
// Ports:
//   clk, reset            system clock, async active-low reset
//   a_req/we/sel/addr/wdata  port A request (level held until a_ack)
//   a_ack/err/rdata       port A completion pulse, error flag, load data
//   b_*                   port B equivalents
//   dm_we/sel/addr/wdata  DM control outputs
//   dm_rdata              DM combinational read data (already extended)
//   busy                  state != IDLE
module dm_access_arbiter #(
  parameter int DM_WORDS = 1024,
  parameter bit B_FIRST  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_sel,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [2:0]  b_sel,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        dm_we,
  output logic [2:0]  dm_sel,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        busy
);

  localparam logic [2:0] DMW  = 3'b000;
  localparam logic [2:0] DMH  = 3'b001;
  localparam logic [2:0] DMB  = 3'b010;
  localparam logic [2:0] DMHU = 3'b101;
  localparam logic [2:0] DMBU = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_b;   // 1 = port B won the most recent grant
  logic        r_gnt_b;    // owner of the access currently in flight
  logic        r_we;
  logic [2:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_a_err;
  logic        r_b_err;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;

  logic        w_take;
  logic        w_a_wins;
  logic        w_sel_ok;
  logic        w_err;
  logic [31:0] w_rdata;

  always_comb begin
    w_next   = r_state;
    w_take   = 1'b0;
    w_a_wins = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req || b_req) begin
          w_take   = 1'b1;
          // A wins when alone, or under contention when B had the last grant
          w_a_wins = a_req && (!b_req || r_last_b);
          w_next   = ACCESS;
        end
      end
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sel_ok = (r_sel == DMW) || (r_sel == DMH) || (r_sel == DMB) ||
               (r_sel == DMHU) || (r_sel == DMBU);
    w_err    = !w_sel_ok ||
               (r_we && ((r_sel == DMHU) || (r_sel == DMBU))) ||
               ((r_sel == DMW) && (r_addr[1:0] != 2'b00)) ||
               (((r_sel == DMH) || (r_sel == DMHU)) && r_addr[0]) ||
               ({2'b00, r_addr[31:2]} >= 32'(DM_WORDS));
    // Stores and rejected accesses return zero
    w_rdata  = (r_we || w_err) ? 32'h0 : dm_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_b  <= ~B_FIRST;
      r_gnt_b   <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
      r_a_rdata <= 32'h0;
      r_b_rdata <= 32'h0;
    end else begin
      if (w_take) begin
        r_gnt_b  <= ~w_a_wins;
        r_last_b <= ~w_a_wins;
        r_we     <= w_a_wins ? a_we    : b_we;
        r_sel    <= w_a_wins ? a_sel   : b_sel;
        r_addr   <= w_a_wins ? a_addr  : b_addr;
        r_wdata  <= w_a_wins ? a_wdata : b_wdata;
      end
      if (r_state == ACCESS) begin
        if (r_gnt_b) begin
          r_b_rdata <= w_rdata;
          r_b_err   <= w_err;
        end else begin
          r_a_rdata <= w_rdata;
          r_a_err   <= w_err;
        end
      end
    end
  end

  // The latched request doubles as the DM bus, so it holds its last issued
  // value outside ACCESS. dm_we decodes the async-reset state and therefore
  // drops the instant reset is asserted.
  assign dm_we    = (r_state == ACCESS) && r_we && !w_err;
  assign dm_sel   = r_sel;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;

  assign a_ack   = (r_state == DONE) && !r_gnt_b;
  assign b_ack   = (r_state == DONE) && r_gnt_b;
  assign a_err   = r_a_err;
  assign b_err   = r_b_err;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign busy    = (r_state != IDLE);

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Shares the single-port data memory between two requesters: port A (CPU MEM stage) and port B (debug/test loader). It arbitrates fairly, registers the winning request, and drives the DM control inputs (write enable, access-width select, address, write data). It validates alignment and address range, then returns registered read data and a one-cycle acknowledge to the winner. It sits between the requesters and the DM.

Parameters:
DM_WORDS, 1024, DM depth in 32-bit words; byte addresses >= 4*DM_WORDS are out of range.
B_FIRST, 0, sets which port wins the first simultaneous contest after reset (0 = A wins first).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
a_req  in  1  port A access request; level held until a_ack
a_we  in  1  port A store (1) / load (0)
a_sel  in  3  port A width code from shared constants: DMW, DMH, DMB, DMHU, DMBU
a_addr  in  32  port A byte address
a_wdata  in  32  port A store data
a_ack  out  1  one-cycle completion pulse for port A
a_err  out  1  valid with a_ack; 1 = access rejected, DM untouched
a_rdata  out  32  port A load result, valid with a_ack
b_req, b_we, b_sel, b_addr, b_wdata  in  1/1/3/32/32  port B equivalents of the a_* inputs
b_ack, b_err, b_rdata  out  1/1/32  port B equivalents of the a_* outputs
dm_we  out  1  DM write enable
dm_sel  out  3  DM width select
dm_addr  out  32  DM byte address
dm_wdata  out  32  DM store data
dm_rdata  in  32  DM combinational read data, already width-extended by DM
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; last-grant = A if B_FIRST=1, else B. Any in-flight access is abandoned. No ack is issued for it, and dm_we drops in the same instant.
- FSM IDLE -> ACCESS -> DONE -> IDLE. Only IDLE samples requests.
- IDLE: if exactly one req=1, that port wins. If both are 1, the port not in last-grant wins. On the edge, latch the winner's we/sel/addr/wdata, update last-grant, and go to ACCESS. With no request, stay in IDLE.
- Error check on the latched request, computed in ACCESS. err=1 if any of the following holds:
  - sel is not one of the five defined codes;
  - we=1 and sel is DMHU or DMBU;
  - DMW with addr[1:0]!=0;
  - DMH/DMHU with addr[0]!=0;
  - addr[31:2] >= DM_WORDS.
- ACCESS (exactly one cycle):
  - dm_sel, dm_addr, dm_wdata come from the latched request;
  - dm_we = we & ~err.
  - On the edge: the winner's rdata <= dm_rdata for an error-free load, else 0. The winner's err is latched.
  - Go to DONE.
- DONE (one cycle): the winner's ack=1; the loser's ack=0. rdata and err hold until that port's next ack. Go to IDLE.
- Latency: req sampled at end of cycle T; DM write commits at end of T+1; ack in T+2. Minimum spacing is one access per 3 cycles.
- A requester still holding req in the IDLE cycle after its ack is treated as a new request.
- Outside ACCESS, dm_we=0 and dm_sel/addr/wdata hold their last issued values.
- Changing inputs mid-access has no effect; only latched values are used.
- With a single requester holding req, it is served back-to-back; fairness applies only under contention.

Test Plan:
- Port A stores DMW 0x12345678 at addr 0x10, then loads DMW at 0x10 -> load a_ack two cycles after sampling; a_rdata=0x12345678, a_err=0; dm_we high for exactly one cycle (store).
- Word at 0x20 = 0x80010000; port B loads DMH at 0x22 -> b_rdata=0xFFFF8001; loads DMHU at 0x22 -> 0x00008001.
- a_req and b_req both held high from reset release (B_FIRST=0) -> acks A,B,A,B, each 3 cycles apart; each rdata corresponds to its own address.
- Port A store DMW at 0x13; port B store DMB at 0x1000 (DM_WORDS=1024); port B store DMHU at 0x4 -> each acked with err=1, dm_we never asserted; DMB store at 0xFFF succeeds.
- Assert reset during ACCESS of a port A store -> dm_we falls without waiting for clk; no a_ack; state returns to IDLE; DM word unchanged.
- Undefined sel code 3'b111 on a load -> ack with err=1, rdata=0.
